// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch controller feeding the UART transmitter.
// Bytes are drained one at a time using a tx_start/tx_active level handshake.
module uart_tx_feeder #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_active,
    output logic              busy
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_overflow;
    state_t            r_state;
    logic              r_tx_start;
    logic [7:0]        r_tx_data;
    logic              r_busy;

    state_t            w_state_nxt;
    logic              w_tx_start_nxt;
    logic [7:0]        w_tx_data_nxt;
    logic              w_pop;
    logic              w_wr_acc;
    logic              w_wr_drop;
    logic [CNT_W-1:0]  w_count_nxt;

    // Writes are judged on the registered full flag; a same-cycle pop does not make room.
    assign w_wr_acc  = wr_en && !r_full && !flush;
    assign w_wr_drop = wr_en && r_full && !flush;

    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else begin
            w_count_nxt = r_count + CNT_W'(w_wr_acc) - CNT_W'(w_pop);
        end
    end

    // Launch FSM: next state and registered output values.
    always_comb begin
        w_state_nxt    = r_state;
        w_tx_start_nxt = r_tx_start;
        w_tx_data_nxt  = r_tx_data;
        w_pop          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_empty && !tx_active) begin
                    w_pop          = 1'b1;
                    w_tx_data_nxt  = r_mem[r_rd_ptr];
                    w_tx_start_nxt = 1'b1;
                    w_state_nxt    = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (tx_active) begin
                    w_tx_start_nxt = 1'b0;
                    w_state_nxt    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!tx_active) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_tx_start_nxt = 1'b0;
                w_state_nxt    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    // Pointer and occupancy bookkeeping; flush overrides everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty    <= (w_count_nxt == '0);
            r_overflow <= w_wr_drop;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_acc) begin
                    r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    assign full     = r_full;
    assign empty    = r_empty;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign busy     = r_busy;

endmodule
